safe_lock_ctrl: RTL and testbench
=================================

Name: safe_lock_ctrl

Overview:
- Controller that sequences the serial unlock FSM, `unloc_mech_moore`, for one code entry at a time.
- Accepts a parallel code word from the keypad front-end over a valid/ready handshake and serialises it MSB-first onto the FSM's `ser_val`/`ser_data` interface.
- Collects the correct/incorrect verdict from the FSM's `output_val`/`output_data`.
- Drives the bolt (`unlocked`), counts failed attempts and enforces a lockout period after repeated failures.

Parameters:
- CODE_W, 4: bits per code word, sent MSB first.
- MAX_FAILS, 3: consecutive failures that trigger lockout.
- OPEN_CYCLES, 16: cycles `unlocked` is held high after a correct code.
- LOCKOUT_CYCLES, 64: cycles inputs are refused during lockout.
- RESP_TIMEOUT, 8: cycles allowed in WAIT_RES before the attempt counts as failed.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- code_valid  in  1  keypad code word valid.
- code_data  in  CODE_W  keypad code word.
- code_ready  out  1  controller can accept a code word.
- ser_val  out  1  serial bit valid, to the unlock FSM.
- ser_data  out  1  serial bit, to the unlock FSM.
- ser_ready  in  1  unlock FSM can accept a bit.
- output_val  in  1  unlock FSM verdict valid.
- output_data  in  1  verdict: 1 = correct, 0 = incorrect.
- unlocked  out  1  bolt release.
- lockout  out  1  lockout active.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- fail_count  out  $clog2(MAX_FAILS+1)  current consecutive-failure count.

Behaviour:
- Fixed reset: `rst` is synchronous and active-high; clock `clk`.
- Reset state:
  - While `rst` is high, state = IDLE.
  - `ser_val`, `ser_data`, `unlocked`, `lockout`, `fail_pulse`, `code_ready` = 0; `fail_count` = 0.
  - `code_ready` = 1 on the first cycle after `rst` falls.
  - `rst` asserted mid-operation (any state) aborts immediately; no result is recorded.
- All outputs are registered.
- States: IDLE, SEND, GAP, WAIT_RES, OPEN, FAIL, LOCKOUT.
- IDLE:
  - `code_ready` = 1.
  - On `code_valid` & `code_ready`: load the shift register and clear the bit counter.
  - Next state SEND, with `ser_val` = 1 and `ser_data` = `code_data[CODE_W-1]` in that cycle.
- SEND:
  - Hold `ser_val` = 1 and `ser_data` stable until `ser_ready` = 1.
  - On transfer, shift left and increment the bit counter.
  - If this was bit CODE_W: go to WAIT_RES, timer = RESP_TIMEOUT. Otherwise go to GAP.
- GAP:
  - Exactly one cycle with `ser_val` = 0, then SEND with the next bit.
  - The mandatory inter-bit gap matches the unlock FSM's one-bit-per-valid-pulse sampling.
- Early verdict: `output_val` = 1 in SEND, GAP or WAIT_RES is taken as the verdict.
  - Remaining bits are abandoned and `ser_val` = 0 from the next cycle.
  - The FSM flags a wrong bit before all CODE_W bits are sent.
- WAIT_RES:
  - Timer decrements each cycle.
  - Reaching 0 with no verdict counts as output_data = 0.
- Verdict 1:
  - Go to OPEN; `fail_count` := 0.
  - `unlocked` = 1 for exactly OPEN_CYCLES cycles, then IDLE.
- Verdict 0: go to FAIL for one cycle, with `fail_pulse` = 1 and `fail_count` += 1.
  - If the new count == MAX_FAILS: go to LOCKOUT. `lockout` = 1 for LOCKOUT_CYCLES cycles, then `fail_count` := 0 and go to IDLE.
  - Otherwise go to IDLE.
- `code_ready` = 0 in every state except IDLE. A code presented outside IDLE is stalled, never dropped.
- `output_val` in IDLE, OPEN, FAIL or LOCKOUT is ignored.
- `output_val` coincident with the final-bit transfer is taken as the verdict; WAIT_RES is skipped.
- `fail_count` saturates at MAX_FAILS and never wraps.

Decomposition:
- `safe_lock_pkg` holds:
  - the state enum `lock_state_t`;
  - the default CODE_W;
  - a verdict encoding: VERDICT_OK = 1, VERDICT_BAD = 0.
- One sub-module, `lock_timer`: loadable down-counter with `load`, `load_val` and `done`.
  - Width = $clog2(max(OPEN_CYCLES, LOCKOUT_CYCLES, RESP_TIMEOUT)+1).
  - One instance, shared by OPEN, LOCKOUT and WAIT_RES; they are mutually exclusive.

Test Plan:
1. Correct code, `ser_ready` = 1, model verdict 1 after the 4th bit.
   - code_data = 4'b1011 → `ser_data` = 1, 0, 1, 1 with one idle cycle between bits.
   - Then `unlocked` = 1 for 16 cycles, `fail_count` = 0.
2. Wrong first bit: code_data = 4'b0xxx, model returns output_val = 1, output_data = 0 after bit 1.
   - Only one bit is sent; `fail_pulse` = 1 for one cycle; `fail_count` = 1; `code_ready` returns in IDLE.
3. Three consecutive wrong codes.
   - Third failure → `lockout` = 1 for 64 cycles, `code_ready` = 0 throughout.
   - `code_valid` held high during lockout is accepted only after return to IDLE; `fail_count` = 0.
4. Backpressure: `ser_ready` = 0 for 5 cycles on bit 2.
   - `ser_val`/`ser_data` are held stable; no bit is skipped or duplicated.
5. No verdict after the 4th bit.
   - After 8 cycles, a failure is recorded (`fail_pulse`, `fail_count` += 1).
6. `rst` asserted mid-SEND and mid-OPEN.
   - Next cycle all outputs = 0 and `fail_count` = 0; `code_ready` = 1 one cycle after `rst` falls.

Source files
------------

// File: rtl/safe_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : safe_lock_pkg
// Purpose  : Shared state type, verdict encoding and defaults for the safe
//            lock controller.
// Revision : 1.0 - initial release
// ============================================================================
package safe_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_GAP      = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_OPEN     = 3'd4,
        ST_FAIL     = 3'd5,
        ST_LOCKOUT  = 3'd6
    } lock_state_t;

    localparam int   DEFAULT_CODE_W = 4;
    localparam logic VERDICT_OK     = 1'b1;
    localparam logic VERDICT_BAD    = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/safe_lock_ctrl_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Purpose  : Loadable down-counter; done while the count sits at zero.
// Revision : 1.0 - initial release
// ============================================================================
module lock_timer #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/safe_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : safe_lock_ctrl
// Purpose  : Serialises keypad codes into the unlock FSM, collects its verdict,
//            drives the bolt and enforces lockout after repeated failures.
// Revision : 1.0 - initial release
// ============================================================================
module safe_lock_ctrl
    import safe_lock_pkg::*;
#(
    parameter int CODE_W         = DEFAULT_CODE_W,
    parameter int MAX_FAILS      = 3,
    parameter int OPEN_CYCLES    = 16,
    parameter int LOCKOUT_CYCLES = 64,
    parameter int RESP_TIMEOUT   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             code_valid,
    input  logic [CODE_W-1:0]                code_data,
    output logic                             code_ready,
    output logic                             ser_val,
    output logic                             ser_data,
    input  logic                             ser_ready,
    input  logic                             output_val,
    input  logic                             output_data,
    output logic                             unlocked,
    output logic                             lockout,
    output logic                             fail_pulse,
    output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);
    localparam int c_tmr_w = $clog2(max3(OPEN_CYCLES, LOCKOUT_CYCLES, RESP_TIMEOUT) + 1);
    localparam int c_fc_w  = $clog2(MAX_FAILS + 1);
    localparam int c_bc_w  = $clog2(CODE_W + 1);
    localparam logic [c_fc_w-1:0] c_fail_max = c_fc_w'(MAX_FAILS);
    localparam logic [c_bc_w-1:0] c_last_bit = c_bc_w'(CODE_W - 1);

    lock_state_t         r_state;
    lock_state_t         w_next;
    lock_state_t         w_verdict_next;
    logic [CODE_W-1:0]   r_shift;
    logic [CODE_W-1:0]   w_shift_next;
    logic [c_bc_w-1:0]   r_bit_cnt;
    logic [c_fc_w-1:0]   w_fail_count_next;
    logic                w_xfer;
    logic                w_last_bit;
    logic                w_accept;
    logic                w_tmr_load;
    logic                w_tmr_done;
    logic [c_tmr_w-1:0]  w_tmr_val;
    logic                w_code_ready_next;
    logic                w_ser_val_next;
    logic                w_ser_data_next;
    logic                w_unlocked_next;
    logic                w_lockout_next;
    logic                w_fail_pulse_next;

    assign w_accept       = (r_state == ST_IDLE) && code_valid && code_ready;
    assign w_xfer         = (r_state == ST_SEND) && ser_ready;
    assign w_last_bit     = (r_bit_cnt == c_last_bit);
    assign w_verdict_next = (output_data == VERDICT_BAD) ? ST_FAIL : ST_OPEN;

    // One timer serves WAIT_RES, OPEN and LOCKOUT; it is reloaded on every
    // state change so each timed state starts from its own full period.
    lock_timer #(
        .WIDTH    (c_tmr_w)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (w_tmr_load),
        .load_val (w_tmr_val),
        .done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            code_ready <= 1'b0;
            ser_val    <= 1'b0;
            ser_data   <= 1'b0;
            unlocked   <= 1'b0;
            lockout    <= 1'b0;
            fail_pulse <= 1'b0;
            fail_count <= '0;
        end else begin
            r_state <= w_next;
            r_shift <= w_shift_next;
            if (r_state == ST_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_xfer) begin
                r_bit_cnt <= r_bit_cnt + c_bc_w'(1);
            end
            code_ready <= w_code_ready_next;
            ser_val    <= w_ser_val_next;
            ser_data   <= w_ser_data_next;
            unlocked   <= w_unlocked_next;
            lockout    <= w_lockout_next;
            fail_pulse <= w_fail_pulse_next;
            fail_count <= w_fail_count_next;
        end
    end

    // A verdict seen while sending or waiting wins over any bit transfer.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) w_next = ST_SEND;
            end
            ST_SEND: begin
                if (output_val)     w_next = w_verdict_next;
                else if (ser_ready) w_next = w_last_bit ? ST_WAIT_RES : ST_GAP;
            end
            ST_GAP: begin
                w_next = output_val ? w_verdict_next : ST_SEND;
            end
            ST_WAIT_RES: begin
                if (output_val)      w_next = w_verdict_next;
                else if (w_tmr_done) w_next = ST_FAIL;
            end
            ST_OPEN: begin
                if (w_tmr_done) w_next = ST_IDLE;
            end
            ST_FAIL: begin
                w_next = (fail_count == c_fail_max) ? ST_LOCKOUT : ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (w_tmr_done) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_shift_next = r_shift;
        if (w_accept) begin
            w_shift_next = code_data;
        end else if (w_xfer) begin
            w_shift_next = r_shift << 1;
        end

        w_fail_count_next = fail_count;
        if (w_next == ST_FAIL) begin
            if (fail_count != c_fail_max) w_fail_count_next = fail_count + c_fc_w'(1);
        end else if ((w_next == ST_OPEN && r_state != ST_OPEN) ||
                     (r_state == ST_LOCKOUT && w_next == ST_IDLE)) begin
            w_fail_count_next = '0;
        end

        // Loaded with period-1 so the state lasts exactly the full period.
        w_tmr_load = (w_next != r_state);
        case (w_next)
            ST_WAIT_RES: w_tmr_val = c_tmr_w'(RESP_TIMEOUT - 1);
            ST_OPEN:     w_tmr_val = c_tmr_w'(OPEN_CYCLES - 1);
            ST_LOCKOUT:  w_tmr_val = c_tmr_w'(LOCKOUT_CYCLES - 1);
            default:     w_tmr_val = '0;
        endcase

        w_code_ready_next = (w_next == ST_IDLE);
        w_ser_val_next    = (w_next == ST_SEND);
        w_ser_data_next   = (w_next == ST_SEND) ? w_shift_next[CODE_W-1] : 1'b0;
        w_unlocked_next   = (w_next == ST_OPEN);
        w_lockout_next    = (w_next == ST_LOCKOUT);
        w_fail_pulse_next = (w_next == ST_FAIL);
    end

endmodule
`default_nettype wire

// File: tb/tb_safe_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_safe_lock_ctrl
// Purpose  : Self-checking bench for safe_lock_ctrl with a behavioural unlock
//            FSM responder and a queue of expected serial bits.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_safe_lock_ctrl;
    import safe_lock_pkg::*;

    localparam int CODE_W = 4;
    localparam int MAX_FAILS = 3;
    localparam int FC_W = $clog2(MAX_FAILS + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              code_valid;
    logic [CODE_W-1:0] code_data;
    logic              code_ready;
    logic              ser_val;
    logic              ser_data;
    logic              ser_ready;
    logic              output_val;
    logic              output_data;
    logic              unlocked;
    logic              lockout;
    logic              fail_pulse;
    logic [FC_W-1:0]   fail_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    safe_lock_ctrl #(
        .CODE_W(CODE_W), .MAX_FAILS(MAX_FAILS), .OPEN_CYCLES(16),
        .LOCKOUT_CYCLES(64), .RESP_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_data(code_data),
        .code_ready(code_ready), .ser_val(ser_val), .ser_data(ser_data),
        .ser_ready(ser_ready), .output_val(output_val), .output_data(output_data),
        .unlocked(unlocked), .lockout(lockout), .fail_pulse(fail_pulse),
        .fail_count(fail_count)
    );

    // Unlock FSM model: compares bits against the secret, answers one cycle
    // after the deciding bit (or in the same cycle when coincident is set).
    logic [CODE_W-1:0] secret = 4'b1011;
    bit mute = 1'b0;
    bit coincident = 1'b0;
    int m_idx = 0;
    bit m_pend = 1'b0;
    bit m_pend_data = 1'b0;
    bit exp_bits[$];
    bit exp_b;
    int n_xfer = 0;
    bit prev_stall = 1'b0;
    bit prev_data = 1'b0;

    always @(negedge clk) begin
        #1;
        output_val  = 1'b0;
        output_data = 1'b0;
        if (rst) begin
            m_idx = 0;
            m_pend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (m_pend) begin
                output_val  = 1'b1;
                output_data = m_pend_data;
                m_pend = 1'b0;
            end
            if (prev_stall) begin
                checks++;
                if (ser_val !== 1'b1 || ser_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: ser_val=%b ser_data=%b required 1/%b", ser_val, ser_data, prev_data);
                end
            end
            prev_stall = ser_val && !ser_ready;
            prev_data  = ser_data;
            if (ser_val && ser_ready) begin
                n_xfer++;
                checks++;
                if (exp_bits.size() == 0) begin
                    errors++;
                    $display("FAIL bit_order: unexpected bit %b with none expected", ser_data);
                end else begin
                    exp_b = exp_bits.pop_front();
                    if (ser_data !== exp_b) begin
                        errors++;
                        $display("FAIL bit_order: got %b required %b", ser_data, exp_b);
                    end
                end
                if (ser_data != secret[CODE_W-1-m_idx]) begin
                    m_idx = 0;
                    if (!mute) begin
                        m_pend = 1'b1;
                        m_pend_data = ~VERDICT_OK;
                    end
                end else if (m_idx == CODE_W - 1) begin
                    m_idx = 0;
                    if (!mute) begin
                        if (coincident) begin
                            output_val  = 1'b1;
                            output_data = VERDICT_OK;
                        end else begin
                            m_pend = 1'b1;
                            m_pend_data = VERDICT_OK;
                        end
                    end
                end else begin
                    m_idx++;
                end
            end
        end
    end

    // Present a code, queue the bits expected on the wire, return on the
    // negedge right after the handshake edge.
    task automatic start_code(input logic [CODE_W-1:0] code, input int nbits);
        int cnt;
        for (int i = 0; i < nbits; i++) exp_bits.push_back(code[CODE_W-1-i]);
        code_valid = 1'b1;
        code_data  = code;
        cnt = 0;
        while (!code_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!code_ready) begin
            checks++; errors++;
            $display("FAIL code_ready_timeout: code_ready=%b required 1", code_ready);
        end
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int cnt;
        cnt = 0;
        while (!code_ready && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        if (!code_ready) begin
            checks++; errors++;
            $display("FAIL idle_timeout: code_ready=%b required 1", code_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        code_valid = 1'b0;
        code_data = '0;
        ser_ready = 1'b1;
        output_val = 1'b0;
        output_data = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({code_ready, ser_val, ser_data, unlocked, lockout, fail_pulse} !== 6'b0 || fail_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy/val/dat/unl/lck/fp=%b%b%b%b%b%b cnt=%0d required all 0",
                     code_ready, ser_val, ser_data, unlocked, lockout, fail_pulse, fail_count);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (code_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: code_ready=%b required 1", code_ready);
        end
    endtask

    task automatic test_correct_code();
        int cnt;
        start_code(4'b1011, 4);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ser_val !== ((i % 2) == 0)) begin
                errors++;
                $display("FAIL gap_pattern[%0d]: ser_val=%b required %b", i, ser_val, (i % 2) == 0);
            end
            @(negedge clk);
        end
        cnt = 0;
        while (unlocked && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL open_length: unlocked cycles=%0d required 16", cnt);
        end
        checks++;
        if (fail_count !== '0 || code_ready !== 1'b1 || exp_bits.size() != 0) begin
            errors++;
            $display("FAIL correct_end: fail_count=%0d code_ready=%b bits_left=%0d required 0/1/0",
                     fail_count, code_ready, exp_bits.size());
        end
    endtask

    task automatic test_wrong_first_bit();
        start_code(4'b0110, 1);
        checks++;
        if (ser_val !== 1'b1 || ser_data !== 1'b0) begin
            errors++;
            $display("FAIL wrong_bit0: ser_val=%b ser_data=%b required 1/0", ser_val, ser_data);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (fail_pulse !== 1'b1 || fail_count !== FC_W'(1) || ser_val !== 1'b0) begin
            errors++;
            $display("FAIL wrong_verdict: fail_pulse=%b fail_count=%0d ser_val=%b required 1/1/0",
                     fail_pulse, fail_count, ser_val);
        end
        @(negedge clk);
        checks++;
        if (fail_pulse !== 1'b0 || code_ready !== 1'b1 || exp_bits.size() != 0) begin
            errors++;
            $display("FAIL wrong_return: fail_pulse=%b code_ready=%b bits_left=%0d required 0/1/0",
                     fail_pulse, code_ready, exp_bits.size());
        end
    endtask

    task automatic test_lockout();
        int cnt;
        for (int k = 2; k <= 3; k++) begin
            start_code(4'b1111, 2);
            cnt = 0;
            while (!fail_pulse && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (fail_pulse !== 1'b1 || fail_count !== FC_W'(k)) begin
                errors++;
                $display("FAIL lockout_fail%0d: fail_pulse=%b fail_count=%0d required 1/%0d",
                         k, fail_pulse, fail_count, k);
            end
        end
        code_valid = 1'b1;
        code_data  = 4'b1011;
        for (int i = 0; i < CODE_W; i++) exp_bits.push_back(code_data[CODE_W-1-i]);
        @(negedge clk);
        cnt = 0;
        while (lockout && cnt < 200) begin
            checks++;
            if (code_ready !== 1'b0) begin
                errors++;
                $display("FAIL lockout_ready[%0d]: code_ready=%b required 0", cnt, code_ready);
            end
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 64) begin
            errors++;
            $display("FAIL lockout_length: lockout cycles=%0d required 64", cnt);
        end
        checks++;
        if (fail_count !== '0 || code_ready !== 1'b1) begin
            errors++;
            $display("FAIL lockout_exit: fail_count=%0d code_ready=%b required 0/1", fail_count, code_ready);
        end
        @(negedge clk);
        code_valid = 1'b0;
        checks++;
        if (ser_val !== 1'b1) begin
            errors++;
            $display("FAIL stalled_code_accepted: ser_val=%b required 1", ser_val);
        end
        wait_idle();
        checks++;
        if (exp_bits.size() != 0) begin
            errors++;
            $display("FAIL lockout_bits: bits_left=%0d required 0", exp_bits.size());
        end
    endtask

    task automatic test_backpressure();
        int cnt;
        int base;
        base = n_xfer;
        start_code(4'b1011, 4);
        cnt = 0;
        while (!(n_xfer == base + 1 && ser_val) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        ser_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (ser_val !== 1'b1 || ser_data !== 1'b0) begin
                errors++;
                $display("FAIL stall_bit2[%0d]: ser_val=%b ser_data=%b required 1/0", i, ser_val, ser_data);
            end
            @(negedge clk);
        end
        ser_ready = 1'b1;
        wait_idle();
        checks++;
        if (n_xfer - base != 4 || exp_bits.size() != 0 || fail_count !== '0) begin
            errors++;
            $display("FAIL stall_total: transfers=%0d bits_left=%0d fail_count=%0d required 4/0/0",
                     n_xfer - base, exp_bits.size(), fail_count);
        end
    endtask

    task automatic test_coincident();
        int cnt;
        int base;
        coincident = 1'b1;
        base = n_xfer;
        start_code(4'b1011, 4);
        cnt = 0;
        while (n_xfer < base + 4 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checks++;
        if (unlocked !== 1'b1 || ser_val !== 1'b0) begin
            errors++;
            $display("FAIL coincident_open: unlocked=%b ser_val=%b required 1/0", unlocked, ser_val);
        end
        cnt = 0;
        while (unlocked && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 16) begin
            errors++;
            $display("FAIL coincident_length: unlocked cycles=%0d required 16", cnt);
        end
        coincident = 1'b0;
        wait_idle();
    endtask

    task automatic test_no_verdict();
        int cnt;
        int base;
        mute = 1'b1;
        base = n_xfer;
        start_code(4'b1011, 4);
        cnt = 0;
        while (n_xfer < base + 4 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        cnt = 0;
        while (!fail_pulse && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt != 8 || fail_count !== FC_W'(1)) begin
            errors++;
            $display("FAIL timeout_fail: wait cycles=%0d fail_count=%0d required 8/1", cnt, fail_count);
        end
        mute = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid();
        int cnt;
        for (int pass = 0; pass < 2; pass++) begin
            start_code(4'b1011, 4);
            if (pass == 1) begin
                cnt = 0;
                while (!unlocked && cnt < 50) begin
                    @(negedge clk);
                    cnt++;
                end
                repeat (3) @(negedge clk);
            end
            rst = 1'b1;
            @(negedge clk);
            exp_bits.delete();
            checks++;
            if ({code_ready, ser_val, ser_data, unlocked, lockout, fail_pulse} !== 6'b0 || fail_count !== '0) begin
                errors++;
                $display("FAIL reset_mid%0d: rdy/val/dat/unl/lck/fp=%b%b%b%b%b%b cnt=%0d required all 0",
                         pass, code_ready, ser_val, ser_data, unlocked, lockout, fail_pulse, fail_count);
            end
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (code_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid%0d_ready: code_ready=%b required 1", pass, code_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_code();
        test_wrong_first_bit();
        test_lockout();
        test_backpressure();
        test_coincident();
        test_no_verdict();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
